// File: rtl/countdown_timer.sv
// MM:SS countdown timer with centisecond resolution and a blinking alarm at zero.
// Define CDT_PROGRESS_BAR_EN to show the remaining fraction as a bar graph on led while counting.
`timescale 1ns/1ps

module countdown_timer #(
  parameter int TICK_DIV    = 500000,
  parameter int MAX_MIN     = 59,
  parameter int BLINK_TICKS = 25
) (
  input  logic        refclk,
  input  logic        reset,
  input  logic        key_start,
  input  logic        key_min,
  input  logic        key_sec,
  input  logic        key_clear,
  output logic [18:0] time_value,
  output logic        running,
  output logic        expired,
  output logic [9:0]  led
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int MW = $clog2(MAX_MIN + 1);

  localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
  localparam logic [MW-1:0] MIN_MAX   = MW'(MAX_MIN);

  localparam int K_SEC   = 0;
  localparam int K_MIN   = 1;
  localparam int K_START = 2;
  localparam int K_CLEAR = 3;

  typedef enum logic [1:0] {
    S_SET,
    S_RUN,
    S_PAUSE,
    S_ALARM
  } state_t;

  state_t        state_reg;
  logic [MW-1:0] preset_min_reg;
  logic [5:0]    preset_sec_reg;
  logic [18:0]   counter_reg;
  logic [PW-1:0] prescaler_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_on_reg;

  logic [3:0]    key_raw;
  logic [3:0]    key_strobe;
  logic [18:0]   preset_total;
  logic          counting;
  logic          tick;

  assign key_raw = {key_clear, key_start, key_min, key_sec};

  // Keys idle high, so the synchronizers reset high to avoid a spurious strobe after reset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      logic sync1_reg;
      logic sync2_reg;
      logic prev_reg;

      always_ff @(posedge refclk or negedge reset) begin
        if (!reset) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          prev_reg  <= 1'b1;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          prev_reg  <= sync2_reg;
        end
      end

      assign key_strobe[gi] = prev_reg & ~sync2_reg;
    end
  endgenerate

  assign preset_total = (19'(preset_min_reg) * 19'd6000) + (19'(preset_sec_reg) * 19'd100);
  assign counting     = (state_reg == S_RUN) || (state_reg == S_ALARM);
  assign tick         = counting && (prescaler_reg == PRE_MAX);

`ifdef CDT_PROGRESS_BAR_EN
  logic [18:0] loaded_reg;
  logic [9:0]  bar;

  // led[k] lit when k < ceil(10*counter/loaded), i.e. k*loaded < 10*counter.
  generate
    for (gi = 0; gi < 10; gi++) begin : g_bar
      assign bar[gi] = (24'(counter_reg) * 24'd10) > (24'(loaded_reg) * 24'(gi));
    end
  endgenerate

  always_ff @(posedge refclk or negedge reset) begin
    if (!reset) begin
      loaded_reg <= '0;
    end else if (state_reg == S_SET && !key_strobe[K_CLEAR] && key_strobe[K_START]
                 && preset_total != 19'd0) begin
      loaded_reg <= preset_total;
    end
  end
`endif

  always_ff @(posedge refclk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_SET;
      preset_min_reg <= '0;
      preset_sec_reg <= '0;
      counter_reg    <= '0;
      prescaler_reg  <= '0;
      blink_cnt_reg  <= '0;
      blink_on_reg   <= 1'b0;
    end else begin
      if (counting) begin
        prescaler_reg <= tick ? '0 : prescaler_reg + PW'(1);
      end

      case (state_reg)
        S_SET: begin
          if (key_strobe[K_CLEAR]) begin
            preset_min_reg <= '0;
            preset_sec_reg <= '0;
          end else if (key_strobe[K_START]) begin
            if (preset_total != 19'd0) begin
              counter_reg   <= preset_total;
              prescaler_reg <= '0;
              state_reg     <= S_RUN;
            end
          end else if (key_strobe[K_MIN]) begin
            preset_min_reg <= (preset_min_reg == MIN_MAX) ? '0 : preset_min_reg + MW'(1);
          end else if (key_strobe[K_SEC]) begin
            preset_sec_reg <= (preset_sec_reg == 6'd59) ? 6'd0 : preset_sec_reg + 6'd1;
          end
        end

        S_RUN: begin
          if (key_strobe[K_CLEAR]) begin
            state_reg <= S_SET;
          end else if (key_strobe[K_START]) begin
            state_reg <= S_PAUSE;
          end else if (tick) begin
            if (counter_reg <= 19'd1) begin
              counter_reg   <= '0;
              state_reg     <= S_ALARM;
              blink_cnt_reg <= '0;
              blink_on_reg  <= 1'b1;
            end else begin
              counter_reg <= counter_reg - 19'd1;
            end
          end
        end

        S_PAUSE: begin
          if (key_strobe[K_CLEAR]) begin
            state_reg <= S_SET;
          end else if (key_strobe[K_START]) begin
            prescaler_reg <= '0;
            state_reg     <= S_RUN;
          end
        end

        S_ALARM: begin
          if (|key_strobe) begin
            state_reg <= S_SET;
          end else if (tick) begin
            if (blink_cnt_reg == BLINK_MAX) begin
              blink_cnt_reg <= '0;
              blink_on_reg  <= ~blink_on_reg;
            end else begin
              blink_cnt_reg <= blink_cnt_reg + BW'(1);
            end
          end
        end

        default: state_reg <= S_SET;
      endcase
    end
  end

  always_comb begin
    time_value = '0;
    led        = '0;
    running    = (state_reg == S_RUN);
    expired    = (state_reg == S_ALARM);
    case (state_reg)
      S_SET: time_value = preset_total;
      S_RUN: begin
        time_value = counter_reg;
`ifdef CDT_PROGRESS_BAR_EN
        led = bar;
`else
        led = 10'b00_0000_0001;
`endif
      end
      S_PAUSE: begin
        time_value = counter_reg;
`ifdef CDT_PROGRESS_BAR_EN
        led = bar;
`else
        led = 10'b00_0000_0010;
`endif
      end
      S_ALARM: led = {10{blink_on_reg}};
      default: begin
        time_value = '0;
        led        = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: preset table, alarm/blink, pause/resume, priority, reset.
`timescale 1ns/1ps

module tb_countdown_timer;

  localparam int TICK_DIV    = 4;
  localparam int BLINK_TICKS = 2;

  localparam int OP_NONE  = 0;
  localparam int OP_MIN   = 1;
  localparam int OP_SEC   = 2;
  localparam int OP_START = 3;
  localparam int OP_CLEAR = 4;

  logic        refclk = 1'b0;
  logic        reset = 1'b0;
  logic        key_start = 1'b1;
  logic        key_min = 1'b1;
  logic        key_sec = 1'b1;
  logic        key_clear = 1'b1;
  logic [18:0] time_value;
  logic        running;
  logic        expired;
  logic [9:0]  led;

  countdown_timer #(
    .TICK_DIV   (TICK_DIV),
    .MAX_MIN    (59),
    .BLINK_TICKS(BLINK_TICKS)
  ) dut (
    .refclk    (refclk),
    .reset     (reset),
    .key_start (key_start),
    .key_min   (key_min),
    .key_sec   (key_sec),
    .key_clear (key_clear),
    .time_value(time_value),
    .running   (running),
    .expired   (expired),
    .led       (led)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    string       name;
    logic [18:0] tv;
    logic        run;
    logic        ex;
    logic [9:0]  led;
  } exp_t;

  typedef struct {
    string       name;
    int          op;
    int          n;
    logic [18:0] tv;
    logic        run;
    logic        ex;
    logic [9:0]  led;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_pass = 0;

  // Expected led while counting: a plain status bit, or the ceil-based bar graph.
  function automatic logic [9:0] run_led(input int cnt, input int loaded, input bit paused);
`ifdef CDT_PROGRESS_BAR_EN
    int nbar;
    logic [10:0] ones;
    nbar = (10 * cnt + loaded - 1) / loaded;
    ones = (11'd1 << nbar) - 11'd1;
    return ones[9:0];
`else
    if (cnt < 0 || loaded < 0) return 10'h3FF;
    return paused ? 10'b00_0000_0010 : 10'b00_0000_0001;
`endif
  endfunction

  task automatic expect_out(input string name, input logic [18:0] tv, input logic run,
                            input logic ex, input logic [9:0] l);
    exp_t e;
    e.name = name;
    e.tv   = tv;
    e.run  = run;
    e.ex   = ex;
    e.led  = l;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty: no expected record queued");
      return;
    end
    e = sb_q.pop_front();
    if (time_value === e.tv && running === e.run && expired === e.ex && led === e.led) begin
      n_pass++;
      $display("ok   %-14s tv=%0d run=%0b exp=%0b led=%b", e.name, time_value, running, expired, led);
    end else begin
      $display("FAIL %s: got tv=%0d run=%0b exp=%0b led=%b, want tv=%0d run=%0b exp=%0b led=%b",
               e.name, time_value, running, expired, led, e.tv, e.run, e.ex, e.led);
    end
  endtask

  task automatic expect_check(input string name, input logic [18:0] tv, input logic run,
                              input logic ex, input logic [9:0] l);
    expect_out(name, tv, run, ex, l);
    check_out();
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic set_key(input int op, input logic v);
    case (op)
      OP_MIN:   key_min = v;
      OP_SEC:   key_sec = v;
      OP_START: key_start = v;
      OP_CLEAR: key_clear = v;
      default: ;
    endcase
  endtask

  task automatic press(input int op, input int n);
    repeat (n) begin
      set_key(op, 1'b0);
      step(4);
      set_key(op, 1'b1);
      step(3);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"reset_idle",  OP_NONE,  0,  19'd0,      1'b0, 1'b0, 10'd0};
    vecs[1] = '{"min_x2",      OP_MIN,   2,  19'd12000,  1'b0, 1'b0, 10'd0};
    vecs[2] = '{"sec_x3",      OP_SEC,   3,  19'd12300,  1'b0, 1'b0, 10'd0};
    vecs[3] = '{"min_wrap",    OP_MIN,   58, 19'd300,    1'b0, 1'b0, 10'd0};
    vecs[4] = '{"sec_wrap",    OP_SEC,   57, 19'd0,      1'b0, 1'b0, 10'd0};
    vecs[5] = '{"min_max",     OP_MIN,   59, 19'd354000, 1'b0, 1'b0, 10'd0};
    vecs[6] = '{"sec_max",     OP_SEC,   59, 19'd359900, 1'b0, 1'b0, 10'd0};
    vecs[7] = '{"clear_set",   OP_CLEAR, 1,  19'd0,      1'b0, 1'b0, 10'd0};
    vecs[8] = '{"start_zero",  OP_START, 1,  19'd0,      1'b0, 1'b0, 10'd0};
    vecs[9] = '{"preset_0001", OP_SEC,   1,  19'd100,    1'b0, 1'b0, 10'd0};

    step(3);
    expect_check("in_reset", 19'd0, 1'b0, 1'b0, 10'd0);
    reset = 1'b1;
    step(2);

    for (int i = 0; i < 10; i++) begin
      press(vecs[i].op, vecs[i].n);
      expect_out(vecs[i].name, vecs[i].tv, vecs[i].run, vecs[i].ex, vecs[i].led);
      check_out();
    end

    // Run 00:01 to zero: RUN at edge 3, ALARM at edge 403, led toggles every 8 edges.
    key_start = 1'b0;
    step(4);
    key_start = 1'b1;
    expect_check("run_start", 19'd100, 1'b1, 1'b0, run_led(100, 100, 1'b0));
    step(398);
    expect_check("run_last", 19'd1, 1'b1, 1'b0, run_led(1, 100, 1'b0));
    step(1);
    expect_check("alarm_entry", 19'd0, 1'b0, 1'b1, 10'h3FF);
    step(7);
    expect_check("blink_on_end", 19'd0, 1'b0, 1'b1, 10'h3FF);
    step(1);
    expect_check("blink_off", 19'd0, 1'b0, 1'b1, 10'h000);
    step(7);
    expect_check("blink_off_end", 19'd0, 1'b0, 1'b1, 10'h000);
    step(1);
    expect_check("blink_on_again", 19'd0, 1'b0, 1'b1, 10'h3FF);
    press(OP_SEC, 1);
    expect_check("alarm_to_set", 19'd100, 1'b0, 1'b0, 10'd0);

    // Pause after 10 ticks while holding the key, then resume.
    key_start = 1'b0;
    step(4);
    key_start = 1'b1;
    step(39);
    expect_check("ten_ticks", 19'd90, 1'b1, 1'b0, run_led(90, 100, 1'b0));
    key_start = 1'b0;
    step(3);
    expect_check("pause_entry", 19'd90, 1'b0, 1'b0, run_led(90, 100, 1'b1));
    step(100);
    expect_check("pause_held", 19'd90, 1'b0, 1'b0, run_led(90, 100, 1'b1));
    key_start = 1'b1;
    step(3);
    key_start = 1'b0;
    step(6);
    expect_check("resume_pre", 19'd90, 1'b1, 1'b0, run_led(90, 100, 1'b0));
    step(1);
    expect_check("resume_tick", 19'd89, 1'b1, 1'b0, run_led(89, 100, 1'b0));
    key_start = 1'b1;
    step(3);

    // Start and clear together while running: clear wins, no PAUSE.
    key_start = 1'b0;
    key_clear = 1'b0;
    step(4);
    key_start = 1'b1;
    key_clear = 1'b1;
    expect_check("start_clear", 19'd100, 1'b0, 1'b0, 10'd0);
    step(20);
    expect_check("still_set", 19'd100, 1'b0, 1'b0, 10'd0);

    // Asynchronous reset in the middle of a run.
    key_start = 1'b0;
    step(4);
    key_start = 1'b1;
    step(20);
    expect_check("run_again", 19'd95, 1'b1, 1'b0, run_led(95, 100, 1'b0));
    #2;
    reset = 1'b0;
    #1;
    expect_check("reset_mid_run", 19'd0, 1'b0, 1'b0, 10'd0);
    @(negedge refclk);
    reset = 1'b1;
    step(3);
    expect_check("presets_lost", 19'd0, 1'b0, 1'b0, 10'd0);

`ifdef CDT_PROGRESS_BAR_EN
    press(OP_SEC, 10);
    key_start = 1'b0;
    step(4);
    key_start = 1'b1;
    step(2199);
    expect_check("bar_550", 19'd450, 1'b1, 1'b0, 10'b00_0001_1111);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
